spram_slot_sched: RTL and testbench

Single-clock, parametrised scheduler that time-slots one single-port SPRAM between LED-panel scan-out reads and renderer writes. Even cycles are read slots and odd cycles are write slots. It also adds multi-bank frame buffering with tear-free bank swap, write backpressure (valid/ready) and overrun flags. It sits between the row/PWM timing logic (rd_start), the renderer (wr_* stream) and the SPRAM primitive.

---
 rtl/pdm_pkg.sv | 8 +
 rtl/row_burst_ctr.sv | 29 ++
 rtl/spram_slot_sched.sv | 86 ++++++++
 tb/tb_spram_slot_sched.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_pkg.sv
// pdm_pkg: shared defaults and slot-phase encoding for the SPRAM slot scheduler
package pdm_pkg;
   localparam int ROWS_DEF  = 4;
   localparam int COLS_DEF  = 8;
   localparam int DW_DEF    = 16;
   localparam int BANKS_DEF = 2;
   typedef enum logic {SLOT_READ = 1'b0, SLOT_WRITE = 1'b1} slot_t;
endpackage

// File: rtl/row_burst_ctr.sv
// row_burst_ctr: row/column walker for one burst of a panel row; last flags the final row of a frame
module row_burst_ctr #(
   parameter int RB = 2,
   parameter int CB = 3
) (
   input  logic          fast_clk,
   input  logic          reset,
   input  logic          start,
   input  logic          advance,
   output logic [RB-1:0] row,
   output logic [CB-1:0] col,
   output logic          busy,
   output logic          last
);
   always_ff @(posedge fast_clk)
      if (reset) begin
         row  <= '1;
         col  <= '0;
         busy <= 1'b0;
      end else if (start && !busy) begin
         row  <= row + 1'b1;
         col  <= '0;
         busy <= 1'b1;
      end else if (advance && busy) begin
         col  <= col + 1'b1;
         if (&col) busy <= 1'b0;
      end
   assign last = &row;
endmodule

// File: rtl/spram_slot_sched.sv
// spram_slot_sched: shares one SPRAM between scan-out reads (even slots) and renderer writes (odd slots)
module spram_slot_sched
   import pdm_pkg::*;
#(
   parameter int ROWS  = ROWS_DEF,
   parameter int COLS  = COLS_DEF,
   parameter int DW    = DW_DEF,
   parameter int BANKS = BANKS_DEF,
   localparam int RB = $clog2(ROWS),
   localparam int CB = $clog2(COLS),
   localparam int BB = $clog2(BANKS),
   localparam int AB = BB + RB + CB
) (
   input  logic          fast_clk,
   input  logic          reset,
   input  logic          rd_start,
   output logic          rd_busy,
   output logic          rd_data_valid,
   output logic [DW-1:0] rd_data,
   output logic [RB-1:0] rd_row_o,
   output logic [CB-1:0] rd_col_o,
   output logic          rd_overrun,
   input  logic          wr_start,
   output logic          wr_busy,
   input  logic          wr_valid,
   input  logic [DW-1:0] wr_data,
   output logic          wr_ready,
   output logic          wr_overrun,
   input  logic          swap_req,
   output logic          frame_swapped,
   output logic [BB-1:0] disp_bank,
   output logic [AB-1:0] spram_addr,
   output logic [DW-1:0] spram_wdata,
   output logic          spram_wren,
   input  logic [DW-1:0] spram_rdata
);
   slot_t         phase;
   logic [RB-1:0] rd_row, wr_row;
   logic [CB-1:0] rd_col, wr_col;
   logic [BB-1:0] render_bank;
   logic          rd_last, wr_last, rd_issue, wr_accept, swap_pending, swap_fire;

   assign render_bank = disp_bank + 1'b1;
   assign rd_issue    = rd_busy && phase == SLOT_READ;
   // gated by reset so an aborted burst cannot strobe a write in the reset cycle
   assign wr_ready    = wr_busy && phase == SLOT_WRITE && !reset;
   assign wr_accept   = wr_valid && wr_ready;
   assign swap_fire   = swap_pending && !rd_busy && !wr_busy && rd_last && wr_last;

   row_burst_ctr #(.RB(RB), .CB(CB)) u_rd (
      .fast_clk, .reset, .start(rd_start), .advance(rd_issue),
      .row(rd_row), .col(rd_col), .busy(rd_busy), .last(rd_last)
   );
   row_burst_ctr #(.RB(RB), .CB(CB)) u_wr (
      .fast_clk, .reset, .start(wr_start), .advance(wr_accept),
      .row(wr_row), .col(wr_col), .busy(wr_busy), .last(wr_last)
   );

   always_ff @(posedge fast_clk)
      if (reset) begin
         phase         <= SLOT_READ;
         disp_bank     <= '0;
         swap_pending  <= 1'b0;
         frame_swapped <= 1'b0;
         rd_data_valid <= 1'b0;
         rd_row_o      <= '0;
         rd_col_o      <= '0;
      end else begin
         phase         <= phase == SLOT_READ ? SLOT_WRITE : SLOT_READ;
         swap_pending  <= !swap_fire && (swap_pending || swap_req);
         frame_swapped <= swap_fire;
         if (swap_fire) disp_bank <= render_bank;
         rd_data_valid <= rd_issue;
         if (rd_issue) begin
            rd_row_o <= rd_row;
            rd_col_o <= rd_col;
         end
      end

   assign rd_overrun  = rd_start && rd_busy && !reset;
   assign wr_overrun  = wr_start && wr_busy && !reset;
   assign rd_data     = rd_data_valid ? spram_rdata : '0;
   assign spram_addr  = phase == SLOT_WRITE ? {render_bank, wr_row, wr_col} : {disp_bank, rd_row, rd_col};
   assign spram_wdata = wr_data;
   assign spram_wren  = wr_accept;
endmodule

// File: tb/tb_spram_slot_sched.sv
// tb_spram_slot_sched: scoreboard bench with an SPRAM model behind the scheduler
module tb_spram_slot_sched;
   localparam int ROWS = 4, COLS = 8, DW = 16, BANKS = 2;
   localparam int RB = $clog2(ROWS), CB = $clog2(COLS), BB = $clog2(BANKS), AB = BB + RB + CB;

   typedef struct {logic [AB-1:0] addr; logic [DW-1:0] data;} wr_exp_t;
   typedef struct {logic [RB-1:0] row; logic [CB-1:0] col; logic [DW-1:0] data;} rd_exp_t;

   logic          fast_clk = 1'b0, reset = 1'b1;
   logic          rd_start = 1'b0, wr_start = 1'b0, wr_valid = 1'b0, swap_req = 1'b0;
   logic [DW-1:0] wr_data = '0, spram_rdata;
   logic          rd_busy, rd_data_valid, rd_overrun, wr_busy, wr_ready, wr_overrun, frame_swapped, spram_wren;
   logic [DW-1:0] rd_data, spram_wdata;
   logic [RB-1:0] rd_row_o;
   logic [CB-1:0] rd_col_o;
   logic [BB-1:0] disp_bank;
   logic [AB-1:0] spram_addr;

   logic [DW-1:0] mem [1 << AB];
   logic [DW-1:0] ref_mem [1 << AB];
   wr_exp_t       wq [$];
   rd_exp_t       rq [$];
   wr_exp_t       w;
   rd_exp_t       r;
   bit            exp_phase = 1'b0, exp_pend = 1'b0;
   logic [RB-1:0] exp_rd_row = '1, exp_wr_row = '1;
   logic [BB-1:0] exp_disp = '0;
   int            n_chk = 0, n_fail = 0, swaps_seen = 0, exp_swaps = 0, wtag = 0;

   spram_slot_sched #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .BANKS(BANKS)) dut (
      .fast_clk(fast_clk), .reset(reset),
      .rd_start(rd_start), .rd_busy(rd_busy), .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .rd_row_o(rd_row_o), .rd_col_o(rd_col_o), .rd_overrun(rd_overrun),
      .wr_start(wr_start), .wr_busy(wr_busy), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .wr_overrun(wr_overrun),
      .swap_req(swap_req), .frame_swapped(frame_swapped), .disp_bank(disp_bank),
      .spram_addr(spram_addr), .spram_wdata(spram_wdata), .spram_wren(spram_wren), .spram_rdata(spram_rdata)
   );

   always #5 fast_clk = ~fast_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial for (int i = 0; i < (1 << AB); i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
   end

   // SPRAM with one-cycle read latency
   always @(posedge fast_clk) begin
      spram_rdata <= mem[spram_addr];
      if (spram_wren) mem[spram_addr] = spram_wdata;
   end

   always @(posedge fast_clk) exp_phase <= reset ? 1'b0 : !exp_phase;

   always @(negedge fast_clk) if (!reset) begin
      if (frame_swapped) swaps_seen++;
      if (wr_ready) chk("ready_slot", exp_phase, 1);
      if (spram_wren) begin
         chk("wr_expected", wq.size() > 0, 1);
         if (wq.size() > 0) begin
            w = wq.pop_front();
            chk("wr_addr", spram_addr, w.addr);
            chk("wr_data", spram_wdata, w.data);
         end
      end
      if (rd_data_valid) begin
         chk("rd_expected", rq.size() > 0, 1);
         if (rq.size() > 0) begin
            r = rq.pop_front();
            chk("rd_row", rd_row_o, r.row);
            chk("rd_col", rd_col_o, r.col);
            chk("rd_data", rd_data, r.data);
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1; rd_start = 1'b0; wr_start = 1'b0; wr_valid = 1'b0; swap_req = 1'b0;
      repeat (2) begin @(posedge fast_clk); #1; end
      wq.delete(); rq.delete();
      @(negedge fast_clk);
      chk("rst_rd_busy", rd_busy, 0);
      chk("rst_wr_busy", wr_busy, 0);
      chk("rst_rd_valid", rd_data_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_rd_row_o", rd_row_o, 0);
      chk("rst_rd_col_o", rd_col_o, 0);
      chk("rst_disp_bank", disp_bank, 0);
      chk("rst_swapped", frame_swapped, 0);
      chk("rst_wren", spram_wren, 0);
      chk("rst_wr_ready", wr_ready, 0);
      reset = 1'b0;
      exp_rd_row = '1; exp_wr_row = '1; exp_disp = '0; exp_pend = 1'b0;
      @(posedge fast_clk); #1;
   endtask

   task automatic settle();
      repeat (3) begin @(posedge fast_clk); #1; end
      if (exp_pend && &exp_rd_row && &exp_wr_row) begin
         exp_disp = exp_disp + 1'b1;
         exp_pend = 1'b0;
         exp_swaps++;
      end
      chk("swaps", swaps_seen, exp_swaps);
      chk("disp_bank", disp_bank, exp_disp);
   endtask

   task automatic pulse_swap();
      swap_req = 1'b1;
      @(posedge fast_clk); #1;
      swap_req = 1'b0;
      exp_pend = 1'b1;
   endtask

   task automatic read_row(input bit ovr);
      logic [RB-1:0] row;
      bit ph;
      int n;
      rd_start = 1'b1;
      @(negedge fast_clk);
      chk("rd_ovr_idle", rd_overrun, 0);
      ph = exp_phase;
      @(posedge fast_clk); #1;
      exp_rd_row = exp_rd_row + 1'b1;
      row = exp_rd_row;
      for (int c = 0; c < COLS; c++) rq.push_back('{row, CB'(c), ref_mem[{exp_disp, row, CB'(c)}]});
      n = 0;
      forever begin
         rd_start = ovr && n == 4;
         @(negedge fast_clk);
         if (rd_start) chk("rd_overrun", rd_overrun, 1);
         if (!rd_busy || n >= 40) break;
         n++;
         @(posedge fast_clk); #1;
      end
      rd_start = 1'b0;
      chk("rd_busy_cycles", n, ph ? 15 : 16);
      @(posedge fast_clk); #1;
      chk("rd_drain", rq.size(), 0);
   endtask

   // mode 0: wr_valid held high; mode 1: wr_valid pattern 1,0,0 repeating
   task automatic write_row(input int mode, input bit ovr, input int abort);
      logic [RB-1:0] row;
      logic [BB-1:0] b;
      logic [DW-1:0] d [COLS];
      int idx, k;
      b = exp_disp + 1'b1;
      wr_start = 1'b1;
      @(negedge fast_clk);
      chk("wr_ovr_idle", wr_overrun, 0);
      @(posedge fast_clk); #1;
      wr_start = 1'b0;
      exp_wr_row = exp_wr_row + 1'b1;
      row = exp_wr_row;
      for (int c = 0; c < COLS; c++) begin
         d[c] = DW'(32'h100 + wtag * 32'h1000 + int'(row) * 16 + c);
         wq.push_back('{{b, row, CB'(c)}, d[c]});
      end
      wtag++;
      idx = 0;
      k = 0;
      while (idx < COLS && k < 100) begin
         if (idx == abort) begin
            if (exp_phase == 1'b0) begin
               wr_valid = 1'b0;
               @(posedge fast_clk); #1;
            end
            reset = 1'b1;
            wr_valid = 1'b1;
            wr_data = d[idx];
            @(negedge fast_clk);
            chk("abort_wren", spram_wren, 0);
            chk("abort_ready", wr_ready, 0);
            wr_valid = 1'b0;
            return;
         end
         wr_valid = mode == 0 || k % 3 == 0;
         wr_data = d[idx];
         wr_start = ovr && k == 2;
         @(negedge fast_clk);
         if (wr_start) chk("wr_overrun", wr_overrun, 1);
         if (wr_valid && wr_ready) begin
            ref_mem[{b, row, CB'(idx)}] = d[idx];
            idx++;
         end
         @(posedge fast_clk); #1;
         wr_start = 1'b0;
         k++;
      end
      wr_valid = 1'b0;
      chk("wr_cols", idx, COLS);
      @(negedge fast_clk);
      chk("wr_busy_end", wr_busy, 0);
      @(posedge fast_clk); #1;
      chk("wr_drain", wq.size(), 0);
   endtask

   initial begin
      do_reset();
      read_row(1'b0); settle();
      write_row(0, 1'b0, -1); settle();
      write_row(1, 1'b0, -1); settle();
      write_row(0, 1'b1, -1); settle();
      write_row(1, 1'b0, -1); settle();
      read_row(1'b1); settle();
      pulse_swap(); settle();
      read_row(1'b0); settle();
      read_row(1'b0); settle();
      repeat (ROWS) begin read_row(1'b0); settle(); end
      write_row(0, 1'b0, 3);
      do_reset(); settle();
      write_row(0, 1'b0, -1); settle();
      read_row(1'b0); settle();
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1);
   end
endmodule
